// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - shared state, token type and depth helper for the PE array sequencer
package pe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } seq_state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } token_t;

  localparam int DEF_ARRAY_LAT = 4;
  localparam int DEF_COLS      = 4;
  localparam int TRACK_DEPTH   = DEF_ARRAY_LAT + DEF_COLS - 1;

  function automatic int track_depth(input int array_lat, input int cols);
    return array_lat + cols - 1;
  endfunction

endpackage

// File: rtl/pe_array_sequencer_skew_line.sv
// rtl/pe_array_sequencer_skew_line.sv - zero-reset delay line; DEPTH of 0 is a plain wire
module skew_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q_o = d_i;
    end else begin : g_dly
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - weight loader, activation skewer and result deskewer around a systolic PE array
module pe_array_sequencer
  import pe_seq_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DATA_W    = 32,
  parameter int ARRAY_LAT = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DATA_W-1:0] a_data,
  input  logic                   a_last,
  output logic                   r_valid,
  output logic [COLS*DATA_W-1:0] r_data,
  output logic                   r_last,
  output logic                   busy,
  output logic [15:0]            vec_cnt,
  output logic                   arr_EN,
  output logic                   arr_SELECTOR,
  output logic                   arr_W_EN,
  output logic [COLS*DATA_W-1:0] arr_weight_above,
  output logic [ROWS*DATA_W-1:0] arr_active_left,
  input  logic [COLS*DATA_W-1:0] arr_sum
);

  localparam int TDEPTH = track_depth(ARRAY_LAT, COLS);
  localparam int LCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  seq_state_e             state_q, state_d;
  logic [LCNT_W-1:0]      load_cnt_q, load_cnt_d;
  logic [15:0]            vec_cnt_q, vec_cnt_d;
  logic                   w_ready_q, a_ready_q, busy_q, wen_q;
  logic [COLS*DATA_W-1:0] weight_q;
  logic [ROWS*DATA_W-1:0] act_q;
  token_t                 tok_q;
  token_t                 track_q [TDEPTH];
  logic                   w_acc, a_acc, track_busy;

  assign w_acc = w_valid & w_ready_q;
  assign a_acc = a_valid & a_ready_q;

  // Tokens still in flight behind the one currently leaving the tracker.
  always_comb begin
    track_busy = tok_q.valid;
    for (int i = 0; i < TDEPTH - 1; i++) track_busy = track_busy | track_q[i].valid;
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (w_acc) begin
          if (load_cnt_q == LCNT_W'(ROWS - 1)) begin
            state_d    = ST_STREAM;
            load_cnt_d = '0;
          end else begin
            state_d    = ST_LOAD;
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (a_acc) begin
          if (vec_cnt_q != 16'hFFFF) vec_cnt_d = vec_cnt_q + 16'd1;
          if (a_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_valid && r_last && !track_busy) begin
          state_d   = ST_IDLE;
          vec_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake readies and array controls are registered from the next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      vec_cnt_q  <= '0;
      w_ready_q  <= 1'b0;
      a_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      wen_q      <= 1'b0;
      weight_q   <= '0;
      act_q      <= '0;
      tok_q      <= '0;
      for (int i = 0; i < TDEPTH; i++) track_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      w_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      a_ready_q  <= (state_d == ST_STREAM);
      busy_q     <= (state_d != ST_IDLE);
      wen_q      <= w_acc;
      weight_q   <= w_acc ? w_data : weight_q;
      act_q      <= a_acc ? a_data : '0;
      tok_q      <= token_t'{valid: a_acc, last: a_acc & a_last};
      track_q[0] <= tok_q;
      for (int i = 1; i < TDEPTH; i++) track_q[i] <= track_q[i-1];
    end
  end

  assign w_ready          = w_ready_q;
  assign a_ready          = a_ready_q;
  assign busy             = busy_q;
  assign arr_EN           = busy_q;
  assign arr_SELECTOR     = w_ready_q;
  assign arr_W_EN         = wen_q;
  assign arr_weight_above = weight_q;
  assign vec_cnt          = vec_cnt_q;
  assign r_valid          = track_q[TDEPTH-1].valid;
  assign r_last           = track_q[TDEPTH-1].last;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    skew_line #(.WIDTH(DATA_W), .DEPTH(r)) u_skew (
      .clk (CLK),
      .rst (RESET),
      .d_i (act_q[r*DATA_W +: DATA_W]),
      .q_o (arr_active_left[r*DATA_W +: DATA_W])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    skew_line #(.WIDTH(DATA_W), .DEPTH(COLS - 1 - c)) u_deskew (
      .clk (CLK),
      .rst (RESET),
      .d_i (arr_sum[c*DATA_W +: DATA_W]),
      .q_o (r_data[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb/tb_pe_array_sequencer.sv - scoreboard bench for pe_array_sequencer with a delay-line array stub
module tb_pe_array_sequencer;
  localparam int ROWS = 4, COLS = 4, DW = 32, LAT = 4;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic                 w_valid, w_ready, a_valid, a_ready, a_last;
  logic [COLS*DW-1:0]   w_data, r_data, arr_weight_above, arr_sum;
  logic [ROWS*DW-1:0]   a_data, arr_active_left;
  logic                 r_valid, r_last, busy, arr_EN, arr_SELECTOR, arr_W_EN;
  logic [15:0]          vec_cnt;

  always #5 CLK = ~CLK;

  pe_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ARRAY_LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .r_valid(r_valid), .r_data(r_data), .r_last(r_last),
    .busy(busy), .vec_cnt(vec_cnt),
    .arr_EN(arr_EN), .arr_SELECTOR(arr_SELECTOR), .arr_W_EN(arr_W_EN),
    .arr_weight_above(arr_weight_above), .arr_active_left(arr_active_left),
    .arr_sum(arr_sum)
  );

  // Array stub: column c returns activation lane c after LAT cycles, i.e. LAT+c after row 0.
  logic [ROWS*DW-1:0] stub_q [LAT];
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < LAT; i++) stub_q[i] <= '0;
    end else begin
      stub_q[0] <= arr_active_left;
      for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
    end
  end
  assign arr_sum = stub_q[LAT-1];

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           total = 0, bad = 0, cyc = 0, results = 0;
  logic [31:0]  wv [4];
  logic [127:0] v1, v2;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic push(input logic [127:0] vec, input logic last);
    sb_q.push_back(exp_t'{data: vec, last: last, cyc: cyc + 8});
  endtask

  always @(negedge CLK) begin
    if (r_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got r_valid=1 want none (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        results++;
        check("r_data", r_data, mon_e.data);
        check("r_last", r_last, mon_e.last);
        check("r_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [127:0] exp_skew(input int k);
    logic [127:0] v = '0;
    for (int r = 0; r < 4; r++) begin
      if (k == 1 + r)      v[r*32 +: 32] = v1[r*32 +: 32];
      else if (k == 2 + r) v[r*32 +: 32] = v2[r*32 +: 32];
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {busy, vec_cnt, arr_EN, arr_SELECTOR, arr_W_EN, w_ready, a_ready, r_valid, r_last}, '0);
    check({name, "_wbus"}, arr_weight_above, '0);
    check({name, "_abus"}, arr_active_left, '0);
    check({name, "_rbus"}, r_data, '0);
  endtask

  task automatic load_w(input logic [31:0] base);
    logic rdy;
    int   guard;
    a_valid = 1'b1;
    a_data  = {4{32'hDEADBEEF}};
    a_last  = 1'b1;
    for (int b = 0; b < ROWS; b++) begin
      w_valid = 1'b1;
      w_data  = {4{base + 32'(b)}};
      guard   = 0;
      do begin
        rdy = w_ready;
        check("load_a_ready", a_ready, 1'b0);
        step();
        guard++;
      end while (!rdy && guard < 8);
      check("load_accept", rdy, 1'b1);
      check("load_wen", arr_W_EN, 1'b1);
      check("load_wdata", arr_weight_above, w_data);
    end
    w_valid = 1'b0;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy !== 1'b0 && g < 40) begin
      step();
      g++;
    end
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_vec_cnt"}, vec_cnt, 16'd0);
    check({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   pat;
    logic [127:0] vec;
    int           vi, r0, b;

    wv[0] = 32'h00000000; wv[1] = 32'h3FE66666; wv[2] = 32'h40400000; wv[3] = 32'hBF199999;
    v1 = {32'hBF999999, 32'h0, 32'h0, 32'h0};
    v2 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h401AC083};
    w_valid = 0; w_data = '0; a_valid = 0; a_data = '0; a_last = 0;

    step(); step();
    check_reset_outputs("reset");
    RESET = 1'b0;
    step();
    check("idle_ctl", {busy, arr_EN, arr_SELECTOR, w_ready, a_ready}, 5'b00110);

    // weight load: beats 0..2, one idle cycle, beat 3
    for (int s = 0; s < 5; s++) begin
      b = (s < 3) ? s : ((s == 3) ? -1 : 3);
      if (b < 0) w_valid = 1'b0;
      else begin
        w_valid = 1'b1;
        w_data  = {4{wv[b]}};
      end
      step();
      check("wload_wen", arr_W_EN, (b >= 0));
      if (b >= 0) check("wload_data", arr_weight_above, {4{wv[b]}});
      check("wload_sel", arr_SELECTOR, (s < 4));
    end
    w_valid = 1'b0;
    check("stream_ctl", {busy, arr_EN, w_ready, a_ready}, 4'b1101);
    step();
    check("wload_wen_after", arr_W_EN, 1'b0);

    // skew: two back-to-back vectors, second ends the job
    a_valid = 1'b1; a_data = v1; a_last = 1'b0; push(v1, 1'b0);
    step();
    a_data = v2; a_last = 1'b1; push(v2, 1'b1);
    check("skew_k1", arr_active_left, exp_skew(1));
    step();
    a_valid = 1'b0; a_last = 1'b0;
    check("skew_k2", arr_active_left, exp_skew(2));
    check("skew_vec_cnt", vec_cnt, 16'd2);
    for (int k = 3; k <= 5; k++) begin
      step();
      check("skew_lanes", arr_active_left, exp_skew(k));
    end
    wait_idle("skew");

    // single vector job
    load_w(32'h0000_0100);
    r0 = results;
    vec = {32'hC0490FDB, 32'h3F800000, 32'h7F7FFFFF, 32'h00000001};
    a_valid = 1'b1; a_data = vec; a_last = 1'b1; push(vec, 1'b1);
    step();
    a_valid = 1'b0; a_last = 1'b0;
    check("single_vec_cnt", vec_cnt, 16'd1);
    wait_idle("single");
    check("single_count", results, r0 + 1);

    // bubbles with w_valid held high throughout stream and drain
    load_w(32'h0000_0200);
    pat = 8'b1110_1011;
    vi = 0;
    r0 = results;
    w_valid = 1'b1;
    w_data = {4{32'hFFFF0000}};
    for (int s = 0; s < 8; s++) begin
      if (pat[s]) begin
        vec = {32'h40000003 + 32'(vi * 16), 32'h40000002 + 32'(vi * 16),
               32'h40000001 + 32'(vi * 16), 32'h40000000 + 32'(vi * 16)};
        a_valid = 1'b1; a_data = vec; a_last = (vi == 5); push(vec, (vi == 5));
        vi++;
      end else begin
        a_valid = 1'b0;
      end
      step();
      check("ign_w_ready", w_ready, 1'b0);
      check("ign_wen", arr_W_EN, 1'b0);
    end
    a_valid = 1'b0; a_last = 1'b0;
    check("bubble_vec_cnt", vec_cnt, 16'd6);
    for (int s = 0; s < 3; s++) begin
      step();
      check("ign_drain_w_ready", w_ready, 1'b0);
      check("ign_drain_wen", arr_W_EN, 1'b0);
    end
    w_valid = 1'b0;
    wait_idle("bubble");
    check("bubble_count", results, r0 + 6);

    // reset two cycles after three accepted vectors; none of them may return
    load_w(32'h0000_0300);
    for (int s = 0; s < 3; s++) begin
      a_valid = 1'b1; a_data = {4{32'h5A5A0000 + 32'(s)}}; a_last = 1'b0;
      step();
    end
    a_valid = 1'b0;
    step(); step();
    RESET = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step();
    RESET = 1'b0;
    for (int s = 0; s < 12; s++) step();
    check("postreset_busy", busy, 1'b0);
    check("postreset_vec_cnt", vec_cnt, 16'd0);
    load_w(32'h0000_0400);
    vec = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    a_valid = 1'b1; a_data = vec; a_last = 1'b1; push(vec, 1'b1);
    step();
    a_valid = 1'b0; a_last = 1'b0;
    wait_idle("fresh");

    for (int s = 0; s < 5; s++) step();
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
